// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 (optionally 8E1) UART receiver, LSB first.
//
// Recovers bytes from the serial line driven by a matching uart_tx. The line
// is double-flopped. The start bit is re-checked at its centre to reject
// glitches. Every following bit is sampled one full bit period later, which
// keeps each sample at the bit centre. A low stop bit is reported as a
// framing error. The receiver then parks until the line returns high, so a
// held-low line cannot start a new frame.
//
// Build option:
//   UART_RX_PARITY_EN  when defined, an even-parity bit follows the data
//                      bits and the parity_err port is present. When it is
//                      undefined, the frame is plain 8N1.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (must be >= 4)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   rx          serial input, idle high, asynchronous to clk
//   data        last correctly framed byte
//   valid       one-cycle strobe: data has just been updated
//   busy        high while a frame is in progress
//   frame_err   one-cycle strobe: stop bit sampled low
//   parity_err  one-cycle strobe alongside valid on a parity mismatch
//               (only with UART_RX_PARITY_EN)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Two-flop synchroniser. Both flops reset to the idle level so that
    // releasing reset cannot look like a start edge.
    logic rx_meta_reg;
    logic rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [7:0]      shreg_reg;
    logic [7:0]      data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            ferr_reg, ferr_next;
    logic            busy_reg;
    logic            sample_en;

`ifdef UART_RX_PARITY_EN
    logic            par_reg, par_next;
    logic            perr_reg, perr_next;
`endif

    // Data-bit sample point: the end of a full bit period counted from the
    // previous centre, which is the centre of the current bit.
    assign sample_en = (state_reg == S_DATA) && (cnt_reg == CNT_LAST);

    // Each shift-register bit loads only at its own sample point. The
    // remaining bits hold, so a partial frame never disturbs data.
    for (genvar gi = 0; gi < 8; gi++) begin : g_shreg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shreg_reg[gi] <= 1'b0;
            end else if (sample_en && (idx_reg == 3'(gi))) begin
                shreg_reg[gi] <= rx_s;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            // Registered from the next state so busy lines up with valid.
            busy_reg  <= (state_next != S_IDLE);
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state logic. The counter free-runs inside a state and is cleared
    // on every transition.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        idx_next   = idx_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
        perr_next  = 1'b0;
`endif

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    // A line that is high again at the start-bit centre was
                    // only a glitch.
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_s;
                    state_next = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shreg_reg;
                        valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                        // Even parity: all nine bits must XOR to zero.
                        perr_next  = (^shreg_reg) ^ par_reg;
`endif
                        // Returning to IDLE at the stop centre lets a start
                        // edge in the second half of the stop bit be caught.
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign data       = data_reg;
    assign valid      = valid_reg;
    assign busy       = busy_reg;
    assign frame_err  = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx with a scoreboard of expected
// bytes. Frames are pushed to the queue as they are driven. A monitor pops
// and compares them whenever valid strobes.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    // Number of edges from the first low sample (E0) to the strobe edge.
    localparam int LAT   = 2 + HALF + (NBITS - 1) * CPB;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip;
    int         perr_count = 0;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_count = 0;
    int ferr_count = 0;
    int busy_cycles = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    int last_ferr_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a falling edge. The next rising edge is
    // therefore E0.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        $display("tx frame byte=%02h stop=%0b at cycle %0d", b, stop_bit, cyc);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(CPB);
    endtask

    // Output monitor: pops the scoreboard on valid and checks strobe rules.
    initial begin
        exp_t e;
        logic valid_prev;
        logic ferr_prev;
        valid_prev = 1'b0;
        ferr_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (valid === 1'b1) begin
                valid_count++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                chk("valid_busy_low", {31'b0, busy}, 32'd0);
                chk("valid_one_cycle", {31'b0, valid_prev}, 32'd0);
                chk("valid_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("rx byte=%02h expected=%02h at cycle %0d", data, e.d, cyc);
                    chk("sb_data", {24'b0, data}, {24'b0, e.d});
`ifdef UART_RX_PARITY_EN
                    chk("sb_parity_err", {31'b0, parity_err}, {31'b0, e.pe});
`endif
                end
            end
            if (frame_err === 1'b1) begin
                ferr_count++;
                last_ferr_cyc = cyc;
                $display("rx frame_err at cycle %0d", cyc);
                chk("ferr_not_with_valid", {31'b0, valid}, 32'd0);
                chk("ferr_one_cycle", {31'b0, ferr_prev}, 32'd0);
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err === 1'b1) begin
                perr_count++;
                chk("perr_with_valid", {31'b0, valid}, 32'd1);
            end
`endif
            valid_prev = valid;
            ferr_prev  = frame_err;
        end
    end

    initial begin
        int v0;
        int f0;
        int b0;
        int start_cyc;
`ifdef UART_RX_PARITY_EN
        int p0;
        par_flip = 1'b0;
`endif
        rst = 1'b0;
        rx  = 1'b1;

        // Reset state
        tick(3);
        chk("reset_data", {24'b0, data}, 32'h00);
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("reset_parity_err", {31'b0, parity_err}, 32'd0);
`endif
        rst = 1'b1;
        tick(5);

        // Single byte: strobe LAT edges after E0
        v0 = valid_count;
        f0 = ferr_count;
        exp_q.push_back({8'hA5, 1'b0});
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(4);
        chk("single_count", valid_count, v0 + 1);
        chk("single_latency", last_valid_cyc - start_cyc, LAT + 1);
        chk("single_data", {24'b0, data}, 32'hA5);
        chk("single_no_ferr", ferr_count, f0);

        // Back-to-back frames with no idle gap
        v0 = valid_count;
        exp_q.push_back({8'hA5, 1'b0});
        exp_q.push_back({8'h3C, 1'b0});
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(4);
        chk("b2b_count", valid_count, v0 + 2);
        chk("b2b_spacing", last_valid_cyc - prev_valid_cyc, FRAME);
        chk("b2b_data", {24'b0, data}, 32'h3C);

        // Glitch: start bit shorter than half a bit
        v0 = valid_count;
        f0 = ferr_count;
        b0 = busy_cycles;
        $display("glitch 5 cycles at cycle %0d", cyc);
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(3 * CPB);
        chk("glitch_busy_cycles", busy_cycles - b0, HALF);
        chk("glitch_no_valid", valid_count, v0);
        chk("glitch_no_ferr", ferr_count, f0);
        chk("glitch_idle", {31'b0, busy}, 32'd0);

        // Framing error, then line held low: no retrigger
        v0 = valid_count;
        f0 = ferr_count;
        start_cyc = cyc;
        send_frame(8'h55, 1'b0);
        tick(40);
        chk("break_busy_high", {31'b0, busy}, 32'd1);
        rx = 1'b1;
        tick(4);
        chk("break_busy_low", {31'b0, busy}, 32'd0);
        tick(3 * CPB);
        chk("ferr_count", ferr_count, f0 + 1);
        chk("ferr_latency", last_ferr_cyc - start_cyc, LAT + 1);
        chk("ferr_no_valid", valid_count, v0);
        chk("ferr_data_kept", {24'b0, data}, 32'h3C);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: valid and parity_err strobe together
        v0 = valid_count;
        p0 = perr_count;
        exp_q.push_back({8'h03, 1'b1});
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        par_flip = 1'b0;
        tick(4);
        chk("parity_valid", valid_count, v0 + 1);
        chk("parity_err_count", perr_count, p0 + 1);
        chk("parity_data", {24'b0, data}, 32'h03);
`endif

        // Reset in the middle of bit 4
        v0 = valid_count;
        f0 = ferr_count;
        $display("mid-frame reset at cycle %0d", cyc);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(i % 2);
            tick(CPB);
        end
        rx = 1'b0;
        tick(HALF);
        rst = 1'b0;
        tick(3);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_data", {24'b0, data}, 32'h00);
        rx  = 1'b1;
        rst = 1'b1;
        tick(3 * CPB);
        chk("midrst_no_valid", valid_count, v0);
        chk("midrst_no_ferr", ferr_count, f0);
        chk("midrst_idle", {31'b0, busy}, 32'd0);

        // Clean frame after the aborted one
        exp_q.push_back({8'h81, 1'b0});
        send_frame(8'h81, 1'b1);
        tick(4);
        chk("post_rst_count", valid_count, v0 + 1);
        chk("post_rst_data", {24'b0, data}, 32'h81);

        tick(10);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
